// File: rtl/tlp_ecrc_append.sv
// Forwards a fragmented TLP stream one DW per cycle and appends a CRC-32 ECRC DW to TD=1 TLPs.
// Latency: one cycle from input acceptance to out_*; the ECRC DW follows the last data DW.
// Backpressure: a single output register; input stalls while it is full and blocked, and during the ECRC slot.
module tlp_ecrc_append #(
  parameter int MAX_TLP_DW = 1028,
  parameter int CNT_W      = 11
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dw,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_td,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_dw,
  output logic        out_sop,
  output logic        out_eop,
  output logic        pkt_err
);

  localparam logic [31:0]      POLY    = 32'h04C11DB7;
  localparam logic [31:0]      SEED    = 32'hFFFFFFFF;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TLP_DW);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_TLP_DW - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_APPEND
  } state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_dw_q, out_dw_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              pkt_err_q, pkt_err_d;
  logic [31:0]       crc_q, crc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              td_q, td_d;

  logic              slot_free;
  logic              accept;
  logic              forced;
  logic              tlp_end;
  logic [31:0]       sop_crc;
  logic [31:0]       dat_crc;

  // 32 serial CRC steps, MSB of the data word first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  // Complement, then mirror the bits inside each byte; byte positions are kept.
  function automatic logic [31:0] ecrc_of(input logic [31:0] crc);
    logic [31:0] c;
    logic [31:0] r;
    c = ~crc;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        r[8*b + k] = c[8*b + 7 - k];
      end
    end
    return r;
  endfunction

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q != S_APPEND) && slot_free;
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_dw    = out_dw_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign pkt_err   = pkt_err_q;

  // Next state, output register load and CRC accumulation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    out_dw_d    = out_dw_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    pkt_err_d   = 1'b0;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    td_d        = td_q;
    forced      = 1'b0;
    tlp_end     = 1'b0;
    // Type[0] and EP are variant bits: forced to 1 for the CRC only, never in the forwarded data.
    sop_crc     = crc_step(SEED, {in_dw[31:25], 1'b1, in_dw[23:15], 1'b1, in_dw[13:0]});
    dat_crc     = crc_step(crc_q, in_dw);

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          if (in_sop) begin
            // A SOP inside an open TLP abandons it; the new TLP restarts cleanly.
            if (state_q == S_DATA) pkt_err_d = 1'b1;
            td_d        = in_td;
            crc_d       = in_td ? sop_crc : SEED;
            cnt_d       = CNT_W'(1);
            out_valid_d = 1'b1;
            out_dw_d    = in_dw;
            out_sop_d   = 1'b1;
            out_eop_d   = in_eop && !in_td;
            if (in_eop) state_d = in_td ? S_APPEND : S_IDLE;
            else        state_d = S_DATA;
          end else if (state_q == S_IDLE) begin
            // Stray DW outside a TLP: dropped.
            pkt_err_d = 1'b1;
          end else begin
            if (td_q) crc_d = dat_crc;
            // Once MAX_TLP_DW DWs have gone by without EOP, this DW closes the TLP.
            forced  = (cnt_q == MAX_CNT);
            tlp_end = in_eop || forced;
            if (!forced) cnt_d = cnt_q + CNT_W'(1);
            if ((cnt_q == MAX_M1) && !in_eop) pkt_err_d = 1'b1;
            out_valid_d = 1'b1;
            out_dw_d    = in_dw;
            out_sop_d   = 1'b0;
            out_eop_d   = tlp_end && !td_q;
            if (tlp_end) state_d = td_q ? S_APPEND : S_IDLE;
          end
        end
      end
      S_APPEND: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_dw_d    = ecrc_of(crc_q);
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, output register and CRC storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_dw_q    <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      pkt_err_q   <= 1'b0;
      crc_q       <= SEED;
      cnt_q       <= '0;
      td_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_dw_q    <= out_dw_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      pkt_err_q   <= pkt_err_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      td_q        <= td_d;
    end
  end

endmodule

// File: doc/tlp_ecrc_append.md
Name: tlp_ecrc_append

Overview:
- DW-serial ECRC generator/appender in the TL TX data-fragmentation path, directly downstream of the TLP buffer fragmentation stage.
- Consumes the fragmented TLP stream one DW per cycle and forwards it unchanged after one register stage.
- For TLPs with TD=1, computes the PCIe ECRC (CRC-32) over the whole TLP and appends it as one extra trailing DW before handing off towards the DLL interface.

Parameters:
- MAX_TLP_DW, 1028, maximum DWs per TLP excluding ECRC (4 header + 1024 payload).
- CNT_W, 11, width of the DW counter; must satisfy 2^CNT_W > MAX_TLP_DW.

Ports:
- clk  input  1  single clock.
- arst  input  1  reset: synchronous, active-high.
- in_valid  input  1  upstream DW valid.
- in_ready  output  1  block can accept a DW this cycle.
- in_dw  input  32  TLP DW; byte0 in [31:24].
- in_sop  input  1  first DW of TLP (header DW0).
- in_eop  input  1  last DW of TLP.
- in_td  input  1  TD bit of the TLP; sampled only on the SOP beat.
- out_valid  output  1  downstream DW valid.
- out_ready  input  1  downstream accepts.
- out_dw  output  32  forwarded DW or ECRC.
- out_sop  output  1  first DW of output TLP.
- out_eop  output  1  last DW of output TLP (the ECRC DW when appended).
- pkt_err  output  1  one-cycle pulse on protocol error.

Behaviour:
- Reset (arst=1 at clk edge): state=IDLE, out_valid=0, out_dw=0, out_sop=0, out_eop=0, pkt_err=0, crc=32'hFFFFFFFF, DW counter=0, td_latched=0.
  - Reset mid-packet discards the output register and any partial CRC.
- Handshake:
  - Transfer occurs when valid&&ready on either side.
  - out_valid is held, and out_dw/out_sop/out_eop stay stable, until out_ready.
  - in_ready = (state!=APPEND) && (!out_valid || out_ready).
- Latency: an accepted DW appears on out_* on the next cycle. Full throughput of 1 DW/cycle while out_ready=1.
- States:
  - IDLE: waits for in_sop. Non-SOP beats are dropped, with pkt_err pulsed. On a SOP beat: latch td_latched=in_td; go to DATA, or stay IDLE if that beat is also EOP with TD=0.
  - DATA: forwards DWs. On an accepted EOP beat: if td_latched, go to APPEND; else go to IDLE.
  - APPEND: in_ready=0. When the register slot frees (!out_valid || out_ready), load out_dw=ECRC, out_sop=0, out_eop=1, then go to IDLE.
  - For a TD=1 TLP, the forwarded last data DW carries out_eop=0, because the ECRC DW carries eop. For TD=0, out_eop mirrors in_eop.
- CRC rules:
  - Polynomial 32'h04C11DB7, seed 32'hFFFFFFFF reloaded on every SOP beat.
  - Updated once per accepted DW while td_latched (or in_td on the SOP beat).
  - Bits are fed in_dw[31] first down to in_dw[0].
  - Variant bits are forced to 1 in the CRC input only on the SOP beat: Type[0]=in_dw[24] and EP=in_dw[14]. Forwarded data is never modified.
  - ECRC = bitwise complement of the final crc, then bit-reversed within each byte, with byte order kept.
  - Next-crc is a combinational 32-step unrolled function; the crc register updates the same cycle as acceptance.
- Counter and errors:
  - Counter increments per accepted data DW in a TLP.
  - SOP while in DATA: pkt_err pulses; the current TLP is abandoned (no ECRC); the new TLP starts with fresh seed and td_latched.
  - Counter reaching MAX_TLP_DW without EOP: pkt_err pulses. The next accepted DW is forced out with out_eop=1 (ECRC still appended if TD=1) and the state returns to IDLE. Further DWs until SOP are dropped with pkt_err.
  - A single-DW TLP with SOP=EOP=1 is legal; with TD=1 it gets an appended ECRC.
- Backpressure in APPEND holds the ECRC DW stable. A new SOP is not accepted until the ECRC transfers.

Test Plan:
- 4-DW MRd header, TD=0, out_ready=1 -> 4 output DWs one cycle later, data identical, out_sop on DW0, out_eop on DW3, no extra DW, pkt_err=0.
- 3-DW header + 2 payload DWs, TD=1 -> 6 output DWs; DW5 has out_eop=1 and equals the golden-model ECRC. Flipping in_dw[24] or in_dw[14] in DW0 yields the same ECRC; flipping in_dw[0] changes it.
- Same TD=1 TLP with out_ready toggling 1,0,0,1 every cycle -> no DW lost or duplicated; ECRC DW held stable while stalled; in_ready=0 during APPEND.
- Back-to-back TD=1 TLPs with in_valid=1 continuously -> exactly one bubble cycle on in_ready per TLP (the ECRC slot); second ECRC matches independent model (seed reset verified).
- SOP injected at DW2 of an open TLP -> pkt_err pulse for 1 cycle; the first TLP gets no ECRC; the second TLP is forwarded intact with correct ECRC.
- arst asserted during APPEND with out_ready=0 -> next cycle out_valid=0, in_ready=1; the following TLP produces a correct ECRC.
